button_debounce: RTL and testbench
==================================

// Module: button_debounce
//
// PURPOSE
//  Conditions the raw push-button before it reaches the dice and the top-level select logic.
//  Synchronises the asynchronous pad input, rejects contact bounce, and emits:
//   - a clean level (drives the dice 'button' input);
//   - one-cycle press/release strobes;
//   - a long-press flag;
//   - a wrapping press counter.
//  Sits directly upstream of the dice in top; one instance per physical button.
//
// PARAMETERS
//  DEBOUNCE_CYCLES  16   consecutive equal synchronised samples needed to accept a level change (>=2)
//  LONG_CYCLES      1024 cycles the clean level must stay high before long_press asserts (>DEBOUNCE_CYCLES)
//  COUNT_W          8    width of press_count
//
// PORTS
//  clk          in   1        system clock; all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  button_raw   in   1        raw pad input, asynchronous, bouncy
//  button       out  1        debounced level; feeds dice.button
//  press_pulse  out  1        one-cycle strobe on the accepted press (button 0->1)
//  release_pulse out 1        one-cycle strobe on the accepted release (button 1->0)
//  long_press   out  1        high while press held >= LONG_CYCLES; cleared on accepted release
//  press_count  out  COUNT_W  number of accepted presses, wraps 2^COUNT_W-1 -> 0
//
// BEHAVIOUR
//  - Reset
//    - rst sampled high: all outputs 0, sync flops 0, counters 0, state IDLE.
//    - rst mid-press: same; no release_pulse emitted; a fresh full debounce is required afterwards.
//  - Synchroniser
//    - 2-flop chain: raw -> s1 -> s2.
//    - FSM sees btn_s = s2, i.e. raw delayed 2 edges.
//  - FSM, all outputs registered:
//    - IDLE (button=0): btn_s=1 -> PRESS_WAIT, stable_cnt=1.
//    - PRESS_WAIT (button=0):
//      - btn_s=0 -> IDLE; bounce rejected, no outputs change.
//      - btn_s=1 with stable_cnt=DEBOUNCE_CYCLES-1 -> PRESSED; at that edge button<=1, press_pulse<=1, press_count<=press_count+1, hold_cnt<=0.
//      - otherwise stable_cnt++.
//    - PRESSED (button=1):
//      - hold_cnt increments, saturating at LONG_CYCLES; when it reaches LONG_CYCLES, long_press<=1.
//      - btn_s=0 -> RELEASE_WAIT, stable_cnt=1.
//    - RELEASE_WAIT (button=1, long_press unchanged):
//      - btn_s=1 -> PRESSED; hold_cnt is NOT cleared, no pulses.
//      - btn_s=0 with stable_cnt=DEBOUNCE_CYCLES-1 -> IDLE; at that edge button<=0, release_pulse<=1, long_press<=0.
//      - otherwise stable_cnt++.
//  - Timing and latency:
//    - press_pulse and release_pulse are high exactly one cycle; they can never both be high in the same cycle.
//    - Latency, raw held stable: button changes DEBOUNCE_CYCLES+2 edges after the first edge that samples the new raw level.
//    - long_press rises LONG_CYCLES edges after button rises, counting only PRESSED cycles. Hold time spent in RELEASE_WAIT is not counted (hold_cnt frozen).
//  - Counter widths:
//    - stable_cnt sized clog2(DEBOUNCE_CYCLES).
//    - hold_cnt sized clog2(LONG_CYCLES+1).
//    - press_count is plain modulo 2^COUNT_W.
//
// TESTING  (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, COUNT_W=8)
//  - Reset:
//    - Stimulus: rst=1 for 2 cycles with raw=1, then rst=0.
//    - Required: all outputs 0 during reset; button rises exactly 6 edges after the first post-reset sampling edge.
//  - Clean press:
//    - Stimulus: raw 0->1, held 30 cycles, then 0.
//    - Required: press_pulse 1 cycle, press_count=1; long_press high 20 cycles after button rise; release_pulse 1 cycle 6 edges after raw falls; long_press 0 with it.
//  - Bounce rejection:
//    - Stimulus: raw toggles 1,0,1,0 every 2 cycles, then stays 0.
//    - Required: button, press_pulse and press_count stay 0.
//  - Release bounce:
//    - Stimulus: while pressed, raw drops for 2 cycles and returns to 1.
//    - Required: button stays 1, no release_pulse, long_press timing delayed only by the RELEASE_WAIT cycles.
//  - Wrap:
//    - Stimulus: 256 clean presses.
//    - Required: press_count reads 0 after the 256th press_pulse.
//  - Reset mid-press:
//    - Stimulus: assert rst while long_press=1.
//    - Required: next cycle all outputs 0, no release_pulse.
//    - Stimulus: raw held 1 after rst drops.
//    - Required: a new press_pulse 6 edges later, press_count=1.

Source files
------------

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Push-button conditioner. Synchronises the raw pad input,
//                rejects contact bounce and produces a clean level, one-cycle
//                press/release strobes, a long-press flag and a wrapping
//                press counter. One instance per physical button.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,   // equal samples needed to accept a change (>=2)
    parameter int LONG_CYCLES     = 1024, // PRESSED cycles before long_press (>DEBOUNCE_CYCLES)
    parameter int COUNT_W         = 8     // width of press_count
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button_raw,
    output logic               button,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_press,
    output logic [COUNT_W-1:0] press_count
);

    // ------------------------------------------------------------------------
    // Counter widths and compare constants
    // ------------------------------------------------------------------------
    localparam int c_STABLE_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W   = $clog2(LONG_CYCLES + 1);

    localparam logic [c_STABLE_W-1:0] c_STABLE_ONE  = c_STABLE_W'(1);
    localparam logic [c_STABLE_W-1:0] c_STABLE_LAST = c_STABLE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_ONE    = c_HOLD_W'(1);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_MAX    = c_HOLD_W'(LONG_CYCLES);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST   = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [COUNT_W-1:0]    c_COUNT_ONE   = COUNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_PRESSED      = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic                  r_s1;
    logic                  r_s2;
    logic [1:0]            r_state;
    logic [c_STABLE_W-1:0] r_stable;
    logic [c_HOLD_W-1:0]   r_hold;
    logic                  r_button;
    logic                  r_press;
    logic                  r_release;
    logic                  r_long;
    logic [COUNT_W-1:0]    r_count;

    logic [1:0]            w_state_nxt;
    logic [c_STABLE_W-1:0] w_stable_nxt;
    logic [c_HOLD_W-1:0]   w_hold_nxt;
    logic                  w_button_nxt;
    logic                  w_press_nxt;
    logic                  w_release_nxt;
    logic                  w_long_nxt;
    logic [COUNT_W-1:0]    w_count_nxt;

    // Two-flop synchroniser for the asynchronous pad input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= button_raw;
            r_s2 <= r_s1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_stable  <= '0;
            r_hold    <= '0;
            r_button  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_stable  <= w_stable_nxt;
            r_hold    <= w_hold_nxt;
            r_button  <= w_button_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // Next-state and next-output decode; strobes default low every cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_stable_nxt  = r_stable;
        w_hold_nxt    = r_hold;
        w_button_nxt  = r_button;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = r_long;
        w_count_nxt   = r_count;

        case (r_state)
            c_ST_IDLE: begin
                if (r_s2) begin
                    w_state_nxt  = c_ST_PRESS_WAIT;
                    w_stable_nxt = c_STABLE_ONE;
                end
            end

            c_ST_PRESS_WAIT: begin
                if (!r_s2) begin
                    // bounce: fall back without touching any output
                    w_state_nxt = c_ST_IDLE;
                end else if (r_stable == c_STABLE_LAST) begin
                    w_state_nxt  = c_ST_PRESSED;
                    w_button_nxt = 1'b1;
                    w_press_nxt  = 1'b1;
                    w_count_nxt  = r_count + c_COUNT_ONE;
                    w_hold_nxt   = '0;
                end else begin
                    w_stable_nxt = r_stable + c_STABLE_ONE;
                end
            end

            c_ST_PRESSED: begin
                // hold time accrues on every PRESSED cycle, including the one
                // that leaves for RELEASE_WAIT; it saturates at LONG_CYCLES
                if (r_hold != c_HOLD_MAX) begin
                    w_hold_nxt = r_hold + c_HOLD_ONE;
                    if (r_hold == c_HOLD_LAST) begin
                        w_long_nxt = 1'b1;
                    end
                end
                if (!r_s2) begin
                    w_state_nxt  = c_ST_RELEASE_WAIT;
                    w_stable_nxt = c_STABLE_ONE;
                end
            end

            c_ST_RELEASE_WAIT: begin
                if (r_s2) begin
                    // release bounce: resume the press with hold time frozen
                    w_state_nxt = c_ST_PRESSED;
                end else if (r_stable == c_STABLE_LAST) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_button_nxt  = 1'b0;
                    w_release_nxt = 1'b1;
                    w_long_nxt    = 1'b0;
                end else begin
                    w_stable_nxt = r_stable + c_STABLE_ONE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign button        = r_button;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_press    = r_long;
    assign press_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Self-checking bench for button_debounce. Directed vector
//                table, hand-written corner sequences and randomised raw
//                input compared against a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int c_DEB  = 4;
    localparam int c_LONG = 20;
    localparam int c_CW   = 8;

    logic            clk;
    logic            rst;
    logic            raw;
    logic            button;
    logic            press_pulse;
    logic            release_pulse;
    logic            long_press;
    logic [c_CW-1:0] press_count;

    int checks;
    int errors;

    button_debounce #(
        .DEBOUNCE_CYCLES (c_DEB),
        .LONG_CYCLES     (c_LONG),
        .COUNT_W         (c_CW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .button_raw    (raw),
        .button        (button),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .press_count   (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: the clean level flips once the synchronised input has
    // disagreed with it for c_DEB consecutive samples; hold time counts
    // cycles spent at level 1 with no pending disagreement.
    // ------------------------------------------------------------------------
    logic m_s1, m_s2, m_level, m_pp, m_rp, m_long;
    int   m_run, m_hold, m_cnt;

    task automatic model_edge(input logic in_rst, input logic in_raw);
        logic bs;
        logic counting;
        if (in_rst) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_pp = 0; m_rp = 0; m_long = 0;
            m_run = 0; m_hold = 0; m_cnt = 0;
        end else begin
            bs       = m_s2;
            m_s2     = m_s1;
            m_s1     = in_raw;
            m_pp     = 0;
            m_rp     = 0;
            counting = m_level && (m_run == 0);
            if (counting && m_hold < c_LONG) begin
                m_hold = m_hold + 1;
                if (m_hold == c_LONG) m_long = 1;
            end
            if (bs != m_level) begin
                m_run = m_run + 1;
                if (m_run == c_DEB) begin
                    m_run = 0;
                    if (bs) begin
                        m_level = 1;
                        m_pp    = 1;
                        m_hold  = 0;
                        m_cnt   = (m_cnt + 1) % (1 << c_CW);
                    end else begin
                        m_level = 0;
                        m_rp    = 1;
                        m_long  = 0;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model and compare every output
    task automatic step(input logic in_rst, input logic in_raw);
        logic [11:0] exp_v;
        rst = in_rst;
        raw = in_raw;
        @(posedge clk);
        model_edge(in_rst, in_raw);
        #1;
        exp_v = {m_level, m_pp, m_rp, m_long, 8'(m_cnt)};
        check("model", 32'({button, press_pulse, release_pulse, long_press, press_count}), 32'(exp_v));
        check("pulse_excl", 32'(press_pulse & release_pulse), 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table: inputs held for n edges, outputs after last edge
    // ------------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       raw;
        int         n;
        logic       button;
        logic       pp;
        logic       rp;
        logic       lp;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic w, input int n, input logic b,
                       input logic pp, input logic rp, input logic lp, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.raw = w; v.n = n; v.button = b; v.pp = pp; v.rp = rp; v.lp = lp; v.cnt = c;
        vt.push_back(v);
    endtask

    logic rv;
    logic rr;
    int   len;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        raw    = 1'b1;

        // reset with raw high, then clean press via reset release
        add(1, 1,  2, 0, 0, 0, 0, 8'd0);
        add(0, 1,  5, 0, 0, 0, 0, 8'd0);
        add(0, 1,  1, 1, 1, 0, 0, 8'd1);
        add(0, 1,  1, 1, 0, 0, 0, 8'd1);
        add(0, 1, 18, 1, 0, 0, 0, 8'd1);
        add(0, 1,  1, 1, 0, 0, 1, 8'd1);
        add(0, 0,  5, 1, 0, 0, 1, 8'd1);
        add(0, 0,  1, 0, 0, 1, 0, 8'd1);
        add(0, 0,  1, 0, 0, 0, 0, 8'd1);
        // bounce rejection
        add(0, 1,  2, 0, 0, 0, 0, 8'd1);
        add(0, 0,  2, 0, 0, 0, 0, 8'd1);
        add(0, 1,  2, 0, 0, 0, 0, 8'd1);
        add(0, 0, 10, 0, 0, 0, 0, 8'd1);
        // press with a 2-cycle release bounce: long_press 2 cycles later
        add(0, 1,  6, 1, 1, 0, 0, 8'd2);
        add(0, 1, 10, 1, 0, 0, 0, 8'd2);
        add(0, 0,  2, 1, 0, 0, 0, 8'd2);
        add(0, 1,  9, 1, 0, 0, 0, 8'd2);
        add(0, 1,  1, 1, 0, 0, 1, 8'd2);
        add(0, 0,  5, 1, 0, 0, 1, 8'd2);
        add(0, 0,  1, 0, 0, 1, 0, 8'd2);

        for (int i = 0; i < vt.size(); i++) begin
            for (int j = 0; j < vt[i].n; j++) step(vt[i].rst, vt[i].raw);
            check($sformatf("vec%0d", i),
                  32'({button, press_pulse, release_pulse, long_press, press_count}),
                  32'({vt[i].button, vt[i].pp, vt[i].rp, vt[i].lp, vt[i].cnt}));
        end

        // wrap: 256 clean presses from reset
        step(1, 0);
        for (int p = 1; p <= 256; p++) begin
            repeat (8) step(0, 1);
            repeat (8) step(0, 0);
            if (p == 255) check("wrap_255", 32'(press_count), 32'd255);
        end
        check("wrap_0", 32'(press_count), 32'd0);

        // reset mid-press while long_press is high
        repeat (30) step(0, 1);
        check("midpress_long", 32'(long_press), 32'd1);
        step(1, 1);
        check("midpress_rst", 32'({button, press_pulse, release_pulse, long_press, press_count}), 32'd0);
        repeat (5) step(0, 1);
        check("midpress_wait", 32'({button, press_pulse}), 32'd0);
        step(0, 1);
        check("midpress_repress", 32'({button, press_pulse, press_count}), 32'({1'b1, 1'b1, 8'd1}));

        // randomised raw runs, occasional long holds and resets
        for (int k = 0; k < 400; k++) begin
            rv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 40))
                                              : int'($urandom_range(1, 7));
            rr  = ($urandom_range(0, 59) == 0);
            for (int j = 0; j < len; j++) step(rr && (j == 0), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
